// File: rtl/ahfp_accum_seq.sv
// Operand sequencer / result collector for a fixed-latency pipelined FP32 adder.
// Reduces an element stream to one sum; optional element counter via AHFP_ACC_COUNT_EN.
module ahfp_accum_seq #(
    parameter int LATENCY = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_res,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
`ifdef AHFP_ACC_COUNT_EN
    ,
    output logic [15:0] out_count
`endif
);

    typedef enum logic [1:0] {ACCUM, DRAIN, OUT} state_t;

    state_t              state;
    logic [LATENCY-1:0]  tag_pipe;
    logic                tag_out;
    logic                others_live;
    logic                issue_tag;
    logic [31:0]         hold;
    logic                hold_v;

    assign tag_out     = tag_pipe[LATENCY-1];
    assign others_live = |tag_pipe[LATENCY-2:0];
    assign in_ready    = (state == ACCUM);

    // Tag bit travels alongside the operands so tag_out lines up with add_res.
    always_comb begin
        add_a     = 32'h0;
        add_b     = 32'h0;
        issue_tag = 1'b0;
        case (state)
            ACCUM: begin
                if (in_valid) begin
                    add_a     = in_data;
                    add_b     = tag_out ? add_res : 32'h0;
                    issue_tag = 1'b1;
                end else if (tag_out) begin
                    add_a     = add_res;
                    issue_tag = 1'b1;
                end
            end
            DRAIN: begin
                if (tag_out && hold_v) begin
                    add_a     = hold;
                    add_b     = add_res;
                    issue_tag = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            tag_pipe  <= '0;
            hold      <= 32'h0;
            hold_v    <= 1'b0;
            out_data  <= 32'h0;
            out_valid <= 1'b0;
        end else begin
            tag_pipe <= {tag_pipe[LATENCY-2:0], issue_tag};
            case (state)
                ACCUM: begin
                    if (in_valid && in_last)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (tag_out) begin
                        if (hold_v) begin
                            hold_v <= 1'b0;
                        end else if (others_live) begin
                            hold   <= add_res;
                            hold_v <= 1'b1;
                        end else begin
                            // Sole surviving partial: this is the final sum.
                            out_data  <= add_res;
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

`ifdef AHFP_ACC_COUNT_EN
    logic [15:0] count;
    assign out_count = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 16'h0;
        end else if (state == ACCUM && in_valid) begin
            if (count != 16'hFFFF)
                count <= count + 16'h1;
        end else if (state == OUT && out_ready) begin
            count <= 16'h0;
        end
    end
`endif

endmodule
